// File: rtl/exec_wb_stage_if.sv
// Decoded-instruction bundle from fetch/decode into execute/write-back.
// No backpressure: the consumer accepts every valid beat.
interface exec_wb_stage_if;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [15:0] valC;

    modport master (
        output in_valid, icode, ifun, rA, rB, valC
    );

    modport slave (
        input in_valid, icode, ifun, rA, rB, valC
    );
endinterface

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: register file, ALU, condition codes.
// E reads operands and computes at accept; W writes the regfile one edge later.
module exec_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    exec_wb_stage_if.slave    dec,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] valE,
    output logic [2:0]        cc,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    logic [DATA_W-1:0] r_rf [8];
    logic              r_w_we;
    logic [3:0]        r_w_dst;
    logic [DATA_W-1:0] r_valE;
    logic [2:0]        r_cc;
    logic              r_err;
    logic [CNT_W-1:0]  r_retired;

    logic [DATA_W-1:0] w_valA;
    logic [DATA_W-1:0] w_valB;
    logic [DATA_W-1:0] w_res;
    logic [7:0]        w_op;
    logic              w_legal;
    logic              w_we;
    logic              w_setcc;
    logic              w_of;
    logic [3:0]        w_dst;
    logic              w_a_s;
    logic              w_b_s;
    logic              w_r_s;

    // Pending W result overrides the regfile; specifiers 8-F read zero
    always_comb begin
        w_valA = '0;
        if (!dec.rA[3]) w_valA = r_rf[dec.rA[2:0]];
        if (r_w_we && (r_w_dst == dec.rA)) w_valA = r_valE;
    end

    always_comb begin
        w_valB = '0;
        if (!dec.rB[3]) w_valB = r_rf[dec.rB[2:0]];
        if (r_w_we && (r_w_dst == dec.rB)) w_valB = r_valE;
    end

    assign w_op  = {dec.icode, dec.ifun};
    assign w_a_s = w_valA[DATA_W-1];
    assign w_b_s = w_valB[DATA_W-1];
    assign w_r_s = w_res[DATA_W-1];

    always_comb begin
        w_legal = 1'b0;
        w_we    = 1'b0;
        w_setcc = 1'b0;
        w_of    = 1'b0;
        w_dst   = 4'hF;
        w_res   = '0;
        case (w_op)
            8'h00: begin
                w_legal = 1'b1;
            end
            8'h10: begin
                w_legal = !dec.rB[3];
                w_we    = 1'b1;
                w_dst   = dec.rB;
                w_res   = {{(DATA_W-16){1'b0}}, dec.valC};
            end
            8'h20: begin
                w_legal = !dec.rA[3] && !dec.rB[3];
                w_we    = 1'b1;
                w_setcc = 1'b1;
                w_dst   = dec.rA;
                w_res   = w_valA + w_valB;
                w_of    = (w_a_s == w_b_s) && (w_r_s != w_a_s);
            end
            8'h21: begin
                w_legal = !dec.rA[3] && !dec.rB[3];
                w_we    = 1'b1;
                w_setcc = 1'b1;
                w_dst   = dec.rA;
                w_res   = w_valA - w_valB;
                w_of    = (w_a_s != w_b_s) && (w_r_s != w_a_s);
            end
            8'h22: begin
                w_legal = !dec.rA[3] && !dec.rB[3];
                w_we    = 1'b1;
                w_setcc = 1'b1;
                w_dst   = dec.rA;
                w_res   = w_valA & w_valB;
            end
            8'h23: begin
                w_legal = !dec.rA[3] && !dec.rB[3];
                w_we    = 1'b1;
                w_setcc = 1'b1;
                w_dst   = dec.rA;
                w_res   = w_valA ^ w_valB;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
            r_w_we    <= 1'b0;
            r_w_dst   <= 4'hF;
            r_valE    <= '0;
            r_cc      <= 3'b100;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_w_we) r_rf[r_w_dst[2:0]] <= r_valE;
            r_w_we <= 1'b0;
            if (dec.in_valid) begin
                if (w_legal) begin
                    r_w_we    <= w_we;
                    r_retired <= r_retired + 1'b1;
                    if (w_we) begin
                        r_w_dst <= w_dst;
                        r_valE  <= w_res;
                    end
                    if (w_setcc)
                        r_cc <= {(w_res == '0), w_r_s, w_of};
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign r0      = r_rf[0];
    assign r1      = r_rf[1];
    assign r2      = r_rf[2];
    assign r3      = r_rf[3];
    assign r4      = r_rf[4];
    assign r5      = r_rf[5];
    assign r6      = r_rf[6];
    assign r7      = r_rf[7];
    assign valA    = w_valA;
    assign valB    = w_valB;
    assign valE    = r_valE;
    assign cc      = r_cc;
    assign err     = r_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage: irmov, ALU ops, forwarding,
// overflow, illegal encodings and asynchronous reset.
module tb_exec_wb_stage;

    logic        clock;
    logic        reset;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [31:0] valA, valB, valE;
    logic [2:0]  cc;
    logic        err;
    logic [15:0] retired;
    int          errs;
    int          checks;

    exec_wb_stage_if u_if ();

    exec_wb_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .dec     (u_if.slave),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .valA    (valA),
        .valB    (valB),
        .valE    (valE),
        .cc      (cc),
        .err     (err),
        .retired (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [31:0] w);
        u_if.in_valid = v;
        u_if.icode    = w[31:28];
        u_if.ifun     = w[27:24];
        u_if.rA       = w[23:20];
        u_if.rB       = w[19:16];
        u_if.valC     = w[15:0];
    endtask

    task automatic issue(input logic [31:0] w);
        drive(1'b1, w);
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h00FF0000);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h00FF0000);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if (r0 !== 32'h0 || r7 !== 32'h0) begin
            $display("FAIL reset_regs r0=%h r7=%h exp 0", r0, r7);
            errs++;
        end
        checks++;
        if (cc !== 3'b100 || err !== 1'b0 || retired !== 16'd0) begin
            $display("FAIL reset_flags cc=%b err=%b ret=%0d exp 100/0/0",
                     cc, err, retired);
            errs++;
        end
    endtask

    task automatic test_irmov();
        logic [31:0] exp;
        logic [31:0] got;
        for (int i = 0; i < 8; i++)
            issue(32'h10F00080 | (i << 16) | i);
        bubble();
        for (int i = 0; i < 8; i++) begin
            exp = 32'h80 + i;
            case (i)
                0: got = r0;
                1: got = r1;
                2: got = r2;
                3: got = r3;
                4: got = r4;
                5: got = r5;
                6: got = r6;
                default: got = r7;
            endcase
            checks++;
            if (got !== exp) begin
                $display("FAIL irmov_r%0d got=%h exp=%h", i, got, exp);
                errs++;
            end
        end
        checks++;
        if (retired !== 16'd8 || cc !== 3'b100 || err !== 1'b0) begin
            $display("FAIL irmov_state ret=%0d cc=%b err=%b exp 8/100/0",
                     retired, cc, err);
            errs++;
        end
    endtask

    task automatic test_alu();
        issue(32'h20010000);
        issue(32'h21230000);
        checks++;
        if (cc !== 3'b010) begin
            $display("FAIL sub_cc got=%b exp=010", cc);
            errs++;
        end
        issue(32'h22450000);
        issue(32'h23670000);
        bubble();
        checks++;
        if (r0 !== 32'h101) begin
            $display("FAIL add_r0 got=%h exp=00000101", r0);
            errs++;
        end
        checks++;
        if (r2 !== 32'hFFFFFFFF) begin
            $display("FAIL sub_r2 got=%h exp=ffffffff", r2);
            errs++;
        end
        checks++;
        if (r4 !== 32'h84 || r6 !== 32'h1) begin
            $display("FAIL and_xor r4=%h r6=%h exp 84/1", r4, r6);
            errs++;
        end
        checks++;
        if (cc !== 3'b000 || retired !== 16'd12) begin
            $display("FAIL alu_state cc=%b ret=%0d exp 000/12", cc, retired);
            errs++;
        end
    endtask

    task automatic test_forwarding();
        issue(32'h10F00005);
        drive(1'b1, 32'h20000000);
        #1;
        checks++;
        if (valA !== 32'h5 || valB !== 32'h5) begin
            $display("FAIL fwd_operands valA=%h valB=%h exp 5/5", valA, valB);
            errs++;
        end
        @(posedge clock);
        #1;
        issue(32'h21000000);
        bubble();
        checks++;
        if (r0 !== 32'h0 || cc !== 3'b100) begin
            $display("FAIL fwd_sub r0=%h cc=%b exp 0/100", r0, cc);
            errs++;
        end
    endtask

    task automatic test_overflow();
        issue(32'h10F04000);
        for (int i = 0; i < 16; i++) issue(32'h20000000);
        bubble();
        checks++;
        if (r0 !== 32'h40000000 || cc !== 3'b000) begin
            $display("FAIL ovf_pre r0=%h cc=%b exp 40000000/000", r0, cc);
            errs++;
        end
        issue(32'h20000000);
        bubble();
        checks++;
        if (r0 !== 32'h80000000 || cc !== 3'b011) begin
            $display("FAIL ovf_add r0=%h cc=%b exp 80000000/011", r0, cc);
            errs++;
        end
        checks++;
        if (retired !== 16'd33) begin
            $display("FAIL ovf_ret got=%0d exp=33", retired);
            errs++;
        end
    endtask

    task automatic test_illegal();
        issue(32'h30000000);
        issue(32'h20890000);
        bubble();
        checks++;
        if (err !== 1'b1) begin
            $display("FAIL ill_err got=%b exp=1", err);
            errs++;
        end
        checks++;
        if (r0 !== 32'h80000000 || cc !== 3'b011 || retired !== 16'd33) begin
            $display("FAIL ill_hold r0=%h cc=%b ret=%0d exp 80000000/011/33",
                     r0, cc, retired);
            errs++;
        end
        issue(32'h10F10007);
        bubble();
        checks++;
        if (r1 !== 32'h7 || err !== 1'b1 || retired !== 16'd34) begin
            $display("FAIL ill_after r1=%h err=%b ret=%0d exp 7/1/34",
                     r1, err, retired);
            errs++;
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h10F3ABCD);
        checks++;
        if (valE !== 32'hABCD) begin
            $display("FAIL mid_valE got=%h exp=0000abcd", valE);
            errs++;
        end
        drive(1'b0, 32'h003F0000);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (r3 !== 32'h0 || valE !== 32'h0 || retired !== 16'd0) begin
            $display("FAIL mid_async r3=%h valE=%h ret=%0d exp 0/0/0",
                     r3, valE, retired);
            errs++;
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (r3 !== 32'h0 || valA !== 32'h0 || valE !== 32'h0) begin
            $display("FAIL mid_hold r3=%h valA=%h valE=%h exp 0/0/0",
                     r3, valA, valE);
            errs++;
        end
        checks++;
        if (cc !== 3'b100 || err !== 1'b0 || retired !== 16'd0) begin
            $display("FAIL mid_flags cc=%b err=%b ret=%0d exp 100/0/0",
                     cc, err, retired);
            errs++;
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_irmov();
        test_alu();
        test_forwarding();
        test_overflow();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/write-back stage; sits directly downstream of the fetch/decode stage.
- Consumes one decoded instruction per clock (icode, ifun, rA, rB, valC) when in_valid is high.
- Owns the 8-entry register file, the ALU and the condition codes.
- Two internal steps: E (operand read + ALU, captured at the accept edge) and W (register write on the following edge). W-to-E forwarding makes back-to-back dependent instructions correct.

Parameters:
DATA_W, 32, register/ALU datapath width
CNT_W, 16, width of retired-instruction counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decoded fields valid this cycle; no backpressure, always accepted
icode  input  4  instruction class
ifun  input  4  function code
rA  input  4  register specifier A (0-7 legal, F = none)
rB  input  4  register specifier B (0-7 legal, F = none)
valC  input  16  immediate field
r0..r7  output  DATA_W each  architectural register contents
valA  output  DATA_W  forwarded operand for rA (combinational)
valB  output  DATA_W  forwarded operand for rB (combinational)
valE  output  DATA_W  W-stage result register
cc  output  3  {ZF,SF,OF}
err  output  1  sticky illegal-instruction flag
retired  output  CNT_W  count of accepted legal instructions

Behaviour:
- Reset (async, immediate):
  - r0..r7 = 0
  - W stage: we = 0, dst = F, valE = 0
  - cc = 3'b100
  - err = 0, retired = 0
  - a pending W write is discarded.
- ISA, decided on {icode,ifun}:
  - 0x00: nop. No write, no cc change, counts as retired.
  - 0x10: irmov. dst = rB; result = zero-extended valC; rA ignored; cc unchanged.
  - 0x20: add. result = valA + valB.
  - 0x21: sub. result = valA - valB.
  - 0x22: and. result = valA & valB.
  - 0x23: xor. result = valA ^ valB.
  - For 0x20-0x23: dst = rA.
  - Anything else: illegal.
- Register specifier rules:
  - For 0x10, rB must be 0-7.
  - For 0x2x, rA and rB must both be 0-7.
  - A value of 8-F where a register is required is illegal.
- Operand read is combinational: valA/valB = R[rA]/R[rB]. If W.we and W.dst equals the specifier, the W result is forwarded instead. Specifier F reads 0.
- Accept edge (in_valid high, legal instruction):
  - W captures we=1 (0 for nop), dst, valE = result.
  - For 0x2x, cc updates:
    - ZF = (result == 0)
    - SF = result[DATA_W-1]
    - OF for add: operands same sign, result sign differs.
    - OF for sub: operands differ in sign, result sign differs from valA.
    - OF = 0 for and/xor.
  - retired increments, wrapping at 2^CNT_W.
- Illegal accept:
  - err set (sticky until reset).
  - W captures we=0; no cc or retired change.
- in_valid low at an edge: W captures we=0 (bubble); all else holds.
- Write edge: the edge after the accept edge writes R[W.dst] = W.valE if W.we.
- Latency: an instruction accepted at edge k is visible on rN after edge k+1.
  - Through forwarding it is usable as an operand by the instruction accepted at edge k+1.
  - There are no stalls.
- A write and a read of the same register in the same cycle resolve via forwarding; the regfile itself never needs read-during-write semantics.

Test Plan:
1. Reset, then accept 0x10F00080..0x10F70087 (irmov into r0..r7), one per cycle -> r0..r7 = 0x80..0x87; retired = 8; cc = 3'b100; err = 0.
2. Continuing from 1, accept 0x20010000, 0x21230000, 0x22450000, 0x23670000 back to back -> r0 = 0x101, r2 = 0xFFFFFFFF, r4 = 0x84, r6 = 0x1; final cc = {0,0,0}; after the sub, cc = {0,1,0}.
3. Forwarding: accept 0x10F00005, then 0x20000000 on the next edge -> r0 = 0xA. Then accept 0x21000000 -> r0 = 0, cc = {1,0,0}.
4. Overflow: irmov r0 = 0x4000, then 16 consecutive 0x20000000 -> r0 = 0x40000000. One more add -> r0 = 0x80000000, cc = {0,1,1}.
5. Illegal: accept 0x30000000 and 0x20890000 -> err = 1; registers, cc and retired unchanged. A following legal irmov still executes; err stays 1.
6. Reset mid-operation: accept 0x10F3ABCD and assert reset before the write edge -> r3 = 0, W.we = 0. With in_valid low for 3 cycles after reset, outputs hold their reset values.
